// File: rtl/ddr_region_reader.sv
`default_nettype none
// ============================================================================
// Module   : ddr_region_reader
// Brief    : AXI4 read master that streams one contiguous DDR region as words,
//            splitting bursts at 4 KB and capturing the config word (id 0).
// Revision : 1.0 - initial release
// ============================================================================
module ddr_region_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 20,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CNT_WIDTH-1:0]  cmd_words,
    input  logic [2:0]            cmd_id,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [2:0]            out_id,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] cfg_word,
    output logic                  cfg_valid,
    output logic                  done,
    output logic                  err
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_SIZE  = $clog2(c_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_DATA = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [8:0]            r_beats;
    logic [2:0]            r_id;
    logic                  r_first;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [2:0]            r_out_id;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_cfg_word;
    logic                  r_cfg_valid;
    logic                  r_done;
    logic                  r_err;

    logic                  w_cmd_hs;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_out_hs;
    logic                  w_misaligned;
    logic [12:0]           w_to_4k;
    logic [12:0]           w_burst;

    assign w_cmd_hs     = cmd_valid && cmd_ready;
    assign w_ar_hs      = m_arvalid && m_arready;
    assign w_r_hs       = m_rvalid && m_rready;
    assign w_out_hs     = r_out_valid && out_ready;
    assign w_misaligned = (cmd_addr & ADDR_WIDTH'(c_BYTES - 1)) != '0;

    // Words left before the next 4 KB page boundary (1..4096/c_BYTES).
    assign w_to_4k = (13'h1000 - {1'b0, r_addr[11:0]}) >> c_SIZE;

    always_comb begin
        w_burst = 13'(MAX_BURST);
        if (w_to_4k < w_burst) begin
            w_burst = w_to_4k;
        end
        if (r_remaining < CNT_WIDTH'(w_burst)) begin
            w_burst = 13'(r_remaining);
        end
    end

    assign m_araddr  = r_addr;
    assign m_arlen   = (r_state == S_AR) ? 8'(w_burst - 13'd1) : 8'd0;
    assign m_arsize  = 3'(c_SIZE);
    assign m_arburst = 2'b01;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_last  = r_out_last;
    assign cfg_word  = r_cfg_word;
    assign cfg_valid = r_cfg_valid;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) begin
                    w_next = (w_misaligned || cmd_words == '0) ? S_FIN : S_AR;
                end
            end
            S_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                m_rready = !r_out_valid || out_ready;
                if (m_rvalid && m_rready && r_beats == 9'd1) begin
                    w_next = (r_remaining == CNT_WIDTH'(1)) ? S_FIN : S_AR;
                end
            end
            S_FIN: begin
                if (!r_out_valid || out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_beats     <= '0;
            r_id        <= '0;
            r_first     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
            r_cfg_word  <= '0;
            r_cfg_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_addr      <= cmd_addr;
                        r_remaining <= cmd_words;
                        r_id        <= cmd_id;
                        r_first     <= 1'b1;
                        r_err       <= w_misaligned;
                        if (cmd_id == 3'd0) begin
                            r_cfg_valid <= 1'b0;
                        end
                    end
                end
                S_AR: begin
                    if (w_ar_hs) begin
                        r_beats <= {1'b0, m_arlen} + 9'd1;
                    end
                end
                S_DATA: begin
                    // A load here overrides the drain clear above, so a word can
                    // leave and the next one arrive in the same cycle.
                    if (w_r_hs) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= m_rdata;
                        r_out_id    <= r_id;
                        r_out_last  <= (r_remaining == CNT_WIDTH'(1));
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
                        r_beats     <= r_beats - 9'd1;
                        r_addr      <= r_addr + ADDR_WIDTH'(c_BYTES);
                        r_first     <= 1'b0;
                        if (m_rresp != 2'b00 || m_rlast != (r_beats == 9'd1)) begin
                            r_err <= 1'b1;
                        end
                        if (r_first && r_id == 3'd0) begin
                            r_cfg_word  <= m_rdata;
                            r_cfg_valid <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    if (!r_out_valid || out_ready) begin
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
